mmio_port_unit: RTL

- Memory-mapped I/O slave on the processor's data-memory bus, alongside the data RAM.
- Consumes the ALU result (address), the register-file read data 2 (store data), and MemWrite/MemRead.
- Drives the processor's 32-bit PortOut and returns debounced, synchronised PortIn data to the write-back mux.
- Single-cycle-core compatible: read data is combinational; all state updates on the rising edge of clk.

---
 rtl/mmio_port_unit_pkg.sv | 42 ++++
 rtl/mmio_port_unit_input_debouncer.sv | 82 ++++++++
 rtl/mmio_port_unit.sv | 124 ++++++++++++
 3 files changed

// File: rtl/mmio_port_unit_pkg.sv
// -----------------------------------------------------------------------------
// mmio_port_unit_pkg
// Shared register offsets, STATUS bit positions and the address-to-register
// decode helper for the memory-mapped I/O port unit.
// -----------------------------------------------------------------------------
package mmio_port_unit_pkg;

    // Byte offsets of the three registers relative to the block base address.
    localparam logic [3:0] OFF_OUT    = 4'h0;
    localparam logic [3:0] OFF_IN     = 4'h4;
    localparam logic [3:0] OFF_STATUS = 4'h8;

    // STATUS register layout.
    localparam int STATUS_CHG_BIT  = 0;
    localparam int STATUS_WCNT_LSB = 8;

    typedef enum logic [1:0] {
        SEL_NONE   = 2'd0,
        SEL_OUT    = 2'd1,
        SEL_IN     = 2'd2,
        SEL_STATUS = 2'd3
    } reg_sel_e;

    // Maps the byte distance from the base address to a register select.
    // Misaligned distances and anything past STATUS select nothing.
    function automatic reg_sel_e decode_sel(input logic [31:0] delta);
        reg_sel_e sel;
        sel = SEL_NONE;
        if (delta[31:4] == 28'h0) begin
            case (delta[3:0])
                OFF_OUT:    sel = SEL_OUT;
                OFF_IN:     sel = SEL_IN;
                OFF_STATUS: sel = SEL_STATUS;
                default:    sel = SEL_NONE;
            endcase
        end else begin
            sel = SEL_NONE;
        end
        return sel;
    endfunction

endpackage

// File: rtl/mmio_port_unit_input_debouncer.sv
// -----------------------------------------------------------------------------
// mmio_port_unit_input_debouncer
// Two-flop synchroniser followed by a stability filter. The debounced value
// only follows the synchronised input once the same value has been sampled on
// DEBOUNCE_CYCLES consecutive edges.
//
// Ports:
//   clk       in   system clock, rising edge
//   reset     in   synchronous active-high reset
//   i_pins    in   asynchronous input pins
//   o_value   out  debounced value (registered)
//   o_update  out  high during the cycle whose rising edge loads a new o_value
// -----------------------------------------------------------------------------
module mmio_port_unit_input_debouncer
    import mmio_port_unit_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_pins,
    output logic [WIDTH-1:0] o_value,
    output logic             o_update
);

    localparam int             CW      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_ONE = CW'(1);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_cand;
    logic [WIDTH-1:0] r_deb;
    logic [CW-1:0]    r_cnt;

    logic [WIDTH-1:0] w_cand_next;
    logic [CW-1:0]    w_cnt_next;
    logic             w_update;

    // Stability counter: a new sample restarts the run at one, a repeated
    // sample extends it and saturates at DEBOUNCE_CYCLES. The debounced value
    // is loaded on the same edge the run length reaches DEBOUNCE_CYCLES.
    always_comb begin
        w_cand_next = r_cand;
        w_cnt_next  = r_cnt;
        if (r_sync2 != r_cand) begin
            w_cand_next = r_sync2;
            w_cnt_next  = CNT_ONE;
        end else if (r_cnt < CNT_MAX) begin
            w_cnt_next  = r_cnt + CNT_ONE;
        end else begin
            w_cnt_next  = r_cnt;
        end
        w_update = (w_cnt_next == CNT_MAX) && (w_cand_next != r_deb);
    end

    // Synchroniser, candidate, counter and debounced value registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_cand  <= '0;
            r_deb   <= '0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_pins;
            r_sync2 <= r_sync1;
            r_cand  <= w_cand_next;
            r_cnt   <= w_cnt_next;
            if (w_update) begin
                r_deb <= w_cand_next;
            end else begin
                r_deb <= r_deb;
            end
        end
    end

    assign o_value  = r_deb;
    assign o_update = w_update;

endmodule

// File: rtl/mmio_port_unit.sv
// -----------------------------------------------------------------------------
// mmio_port_unit
// Memory-mapped I/O slave on the data-memory bus. Registers:
//   BASE+0 OUT    read/write, drives PortOut
//   BASE+4 IN     read-only, debounced PortIn
//   BASE+8 STATUS bit0 InChanged (clear on read / write-1-to-clear),
//                 bits 15:8 count of OUT writes modulo 256
//
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   Address, WriteData    byte address and store data
//   MemWrite, MemRead     store / load strobes
//   PortIn                asynchronous input pins
//   Hit                   combinational address match
//   ReadData              combinational load data (0 unless Hit and MemRead)
//   PortOut               registered output port
//   InChanged             sticky input-change flag
// -----------------------------------------------------------------------------
module mmio_port_unit
    import mmio_port_unit_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR       = 32'h1001_0024,
    parameter int          IN_WIDTH        = 8,
    parameter int          DEBOUNCE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         Address,
    input  logic [31:0]         WriteData,
    input  logic                MemWrite,
    input  logic                MemRead,
    input  logic [IN_WIDTH-1:0] PortIn,
    output logic                Hit,
    output logic [31:0]         ReadData,
    output logic [31:0]         PortOut,
    output logic                InChanged
);

    logic [31:0]         r_port_out;
    logic [7:0]          r_wcnt;
    logic                r_in_changed;

    logic [31:0]         w_delta;
    reg_sel_e            w_sel;
    logic                w_out_wr;
    logic                w_status_clr;
    logic [IN_WIDTH-1:0] w_deb;
    logic                w_deb_update;
    logic [31:0]         w_in_word;
    logic [31:0]         w_status_word;

    mmio_port_unit_input_debouncer #(
        .WIDTH           (IN_WIDTH),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clk      (clk),
        .reset    (reset),
        .i_pins   (PortIn),
        .o_value  (w_deb),
        .o_update (w_deb_update)
    );

    // Decoding on the distance from the base keeps the three registers
    // contiguous even when the base is not 16-byte aligned.
    assign w_delta      = Address - BASE_ADDR;
    assign w_sel        = decode_sel(w_delta);
    assign Hit          = (w_sel != SEL_NONE);
    assign w_out_wr     = MemWrite && (w_sel == SEL_OUT);
    assign w_status_clr = (w_sel == SEL_STATUS) &&
                          (MemRead || (MemWrite && WriteData[0]));

    // Readback words for IN and STATUS.
    always_comb begin
        w_in_word                              = 32'h0;
        w_in_word[IN_WIDTH-1:0]                = w_deb;
        w_status_word                          = 32'h0;
        w_status_word[STATUS_CHG_BIT]          = r_in_changed;
        w_status_word[STATUS_WCNT_LSB +: 8]    = r_wcnt;
    end

    // Combinational read mux; shows pre-edge contents even during a write.
    always_comb begin
        ReadData = 32'h0;
        if (MemRead) begin
            case (w_sel)
                SEL_OUT:    ReadData = r_port_out;
                SEL_IN:     ReadData = w_in_word;
                SEL_STATUS: ReadData = w_status_word;
                default:    ReadData = 32'h0;
            endcase
        end else begin
            ReadData = 32'h0;
        end
    end

    // OUT register, OUT write counter and the sticky change flag.
    // A debounced update on the same edge as a clear keeps the flag set.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_port_out   <= 32'h0;
            r_wcnt       <= 8'h0;
            r_in_changed <= 1'b0;
        end else begin
            if (w_out_wr) begin
                r_port_out <= WriteData;
                r_wcnt     <= r_wcnt + 8'h1;
            end else begin
                r_port_out <= r_port_out;
                r_wcnt     <= r_wcnt;
            end
            if (w_deb_update) begin
                r_in_changed <= 1'b1;
            end else if (w_status_clr) begin
                r_in_changed <= 1'b0;
            end else begin
                r_in_changed <= r_in_changed;
            end
        end
    end

    assign PortOut   = r_port_out;
    assign InChanged = r_in_changed;

endmodule
